// File: rtl/z80_io_write_fifo_if.sv
// Bus-side and drain-side signals of the Z80 I/O-write capture FIFO.
// master drives the Z80 bus and drain controls; slave is the capture block.
interface z80_io_write_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          A;
  logic [7:0]          D;
  logic                IORQ;
  logic                WR;
  logic                M1;
  logic                DATA_DIR;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;
  logic                clr_overflow;

  modport master (
    output A, D, IORQ, WR, M1,
    output rd_ready, clr_overflow,
    input  DATA_DIR, rd_data, rd_valid,
    input  fifo_count, overflow
  );

  modport slave (
    input  A, D, IORQ, WR, M1,
    input  rd_ready, clr_overflow,
    output DATA_DIR, rd_data, rd_valid,
    output fifo_count, overflow
  );
endinterface

// File: rtl/z80_io_write_fifo.sv
// Z80 OUT-cycle capture: decodes one I/O port, queues one byte per
// bus cycle and offers it to FPGA logic over a valid/ready drain.
module z80_io_write_fifo #(
  parameter logic [7:0] PORT_ADDR  = 8'hC0,
  parameter logic [7:0] ADDR_MASK  = 8'hFF,
  parameter int         DEPTH_LOG2 = 4
) (
  input logic CLK,
  input logic RST,
  z80_io_write_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [7:0] a_q;
  logic [7:0] d_q;
  logic       iorq_q;
  logic       wr_q;
  logic       m1_q;
  logic       hit_d;
  logic       hold;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       count;
  logic       ovf;

  logic hit;
  logic push;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    hit = ~iorq_q & ~wr_q & m1_q &
          ((a_q & ADDR_MASK) == (PORT_ADDR & ADDR_MASK));
    push    = hit & ~hit_d;
    full    = (count == FULL);
    empty   = (count == '0);
    pop     = ~empty & bus.rd_ready;
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // hold keeps hit_d high for the first edge after reset, so a write
  // already on the bus when RST drops needs a fresh assertion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= 8'h00;
      d_q    <= 8'h00;
      iorq_q <= 1'b1;
      wr_q   <= 1'b1;
      m1_q   <= 1'b1;
      hit_d  <= 1'b1;
      hold   <= 1'b1;
    end else begin
      a_q    <= bus.A;
      d_q    <= bus.D;
      iorq_q <= bus.IORQ;
      wr_q   <= bus.WR;
      m1_q   <= bus.M1;
      hit_d  <= hit | hold;
      hold   <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)     rd_ptr <= rd_ptr + ptr_t'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      if (drop)                  ovf <= 1'b1;
      else if (bus.clr_overflow) ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= d_q;
  end

  assign bus.DATA_DIR   = 1'b0;
  assign bus.rd_data    = mem[rd_ptr];
  assign bus.rd_valid   = ~empty;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_z80_io_write_fifo.sv
// Random and directed bus traffic against a queue-based model
// of the Z80 I/O-write capture FIFO.
module tb_z80_io_write_fifo;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  typedef enum int {K_OUT, K_IN, K_INTA, K_MEMWR} kind_e;

  logic clk = 1'b0;
  logic rst = 1'b1;

  z80_io_write_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  z80_io_write_fifo #(
    .PORT_ADDR (8'hC0),
    .ADDR_MASK (8'hFF),
    .DEPTH_LOG2(DL2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  byte unsigned mq[$];
  bit           m_ovf;
  bit           pend;
  byte unsigned pend_data;
  int           n_chk;
  int           n_err;
  int           rdy_pct;
  int           clr_pct;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock: model the edge from the inputs now on the bus,
  // then compare at the following negedge.
  task automatic tick(input bit start);
    bit do_pop;
    bit do_clr;
    bit dropped;
    do_pop  = !rst && mq.size() > 0 && bus.rd_ready === 1'b1;
    do_clr  = bus.clr_overflow;
    dropped = 1'b0;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      pend  = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (pend) begin
        if (mq.size() < DEPTH) mq.push_back(pend_data);
        else dropped = 1'b1;
      end
      if (dropped)     m_ovf = 1'b1;
      else if (do_clr) m_ovf = 1'b0;
      pend      = start;
      pend_data = bus.D;
    end
    @(negedge clk);
    check("count", 32'(bus.fifo_count), mq.size());
    check("valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
    check("ovf", 32'(bus.overflow), 32'(m_ovf));
    check("dir", 32'(bus.DATA_DIR), 32'd0);
    if (mq.size() != 0)
      check("data", 32'(bus.rd_data), 32'(mq[0]));
  endtask

  task automatic ctrl(input bit force_rdy);
    bus.rd_ready = force_rdy ||
      ($urandom_range(0, 99) < rdy_pct);
    bus.clr_overflow =
      ($urandom_range(0, 99) < clr_pct);
  endtask

  task automatic drive_idle();
    bus.IORQ = 1'b1;
    bus.WR   = 1'b1;
    bus.M1   = 1'b1;
    bus.A    = 8'($urandom);
    bus.D    = 8'($urandom);
  endtask

  task automatic drive(input kind_e k,
                       input logic [7:0] a,
                       input logic [7:0] d);
    bus.A  = a;
    bus.D  = d;
    bus.M1 = 1'b1;
    case (k)
      K_OUT: begin bus.IORQ = 1'b0; bus.WR = 1'b0; end
      K_IN:  begin bus.IORQ = 1'b0; bus.WR = 1'b1; end
      K_INTA: begin
        bus.IORQ = 1'b0;
        bus.M1   = 1'b0;
        bus.WR   = 1'($urandom_range(0, 1));
      end
      default: begin bus.IORQ = 1'b1; bus.WR = 1'b0; end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      ctrl(1'b0);
      tick(1'b0);
    end
  endtask

  task automatic txn(input kind_e k,
                     input logic [7:0] a,
                     input logic [7:0] d,
                     input int len,
                     input int rdy_at,
                     input int gap);
    bit q;
    q = (k == K_OUT) && (a == 8'hC0);
    for (int i = 0; i < len; i++) begin
      drive(k, a, d);
      ctrl(i == rdy_at);
      tick(q && i == 0);
    end
    idle(gap);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rdy_pct = 0;
    clr_pct = 0;
    m_ovf   = 1'b0;
    pend    = 1'b0;
    drive_idle();
    bus.rd_ready     = 1'b0;
    bus.clr_overflow = 1'b0;

    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    idle(2);

    // single OUT held three clocks, no drain
    txn(K_OUT, 8'hC0, 8'h5A, 3, -1, 2);
    check("t1_count", 32'(bus.fifo_count), 32'd1);
    check("t1_data", 32'(bus.rd_data), 32'h5A);
    rdy_pct = 100;
    idle(2);
    rdy_pct = 0;

    // wrong port and interrupt acknowledge
    txn(K_OUT, 8'hC1, 8'h11, 2, -1, 1);
    txn(K_INTA, 8'hC0, 8'h22, 2, -1, 1);
    txn(K_IN, 8'hC0, 8'h33, 2, -1, 1);
    txn(K_MEMWR, 8'hC0, 8'h44, 2, -1, 1);
    check("t2_count", 32'(bus.fifo_count), 32'd0);

    // overfill
    for (int i = 1; i <= 5; i++)
      txn(K_OUT, 8'hC0, 8'(i), 2, -1, 1);
    check("t3_count", 32'(bus.fifo_count), 32'd4);
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3_pop", 32'(bus.rd_data), 32'(i));
      drive_idle();
      bus.rd_ready = 1'b1;
      bus.clr_overflow = 1'b0;
      tick(1'b0);
    end
    check("t3_empty", 32'(bus.rd_valid), 32'd0);
    clr_pct = 100;
    idle(1);
    clr_pct = 0;
    check("t3_clr", 32'(bus.overflow), 32'd0);

    // push and pop together while full
    for (int i = 0; i < 4; i++)
      txn(K_OUT, 8'hC0, 8'(8'h60 + i), 1, -1, 1);
    txn(K_OUT, 8'hC0, 8'h77, 3, 1, 1);
    check("t4_count", 32'(bus.fifo_count), 32'd4);
    check("t4_ovf", 32'(bus.overflow), 32'd0);
    check("t4_head", 32'(bus.rd_data), 32'h61);

    // back-to-back OUTs, drain always ready
    rdy_pct = 100;
    for (int i = 0; i < 40; i++)
      txn(K_OUT, 8'hC0, 8'($urandom),
          $urandom_range(1, 3), -1, 1);
    idle(3);
    check("t5_empty", 32'(bus.fifo_count), 32'd0);

    // reset while a write is held on the bus
    rdy_pct = 0;
    for (int i = 0; i < 5; i++)
      txn(K_OUT, 8'hC0, 8'(8'h90 + i), 1, -1, 1);
    drive(K_OUT, 8'hC0, 8'h33);
    ctrl(1'b0);
    tick(1'b1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    check("t6_count", 32'(bus.fifo_count), 32'd0);
    check("t6_ovf", 32'(bus.overflow), 32'd0);
    idle(1);
    txn(K_OUT, 8'hC0, 8'h34, 2, -1, 1);
    check("t6_push", 32'(bus.rd_data), 32'h34);

    // random traffic
    clr_pct = 5;
    for (int i = 0; i < 250; i++) begin
      kind_e k;
      logic [7:0] a;
      if (i % 25 == 0) rdy_pct = 33 * $urandom_range(0, 3);
      k = kind_e'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = 8'hC0;
      else a = 8'($urandom);
      txn(k, a, 8'($urandom),
          $urandom_range(1, 4), -1,
          $urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end
endmodule
